slice_sequencer: RTL and testbench



---
 rtl/slice_seq_pkg.sv | 28 ++
 rtl/slice_sequencer_mux.sv | 25 ++
 rtl/slice_sequencer.sv | 150 +++++++++++++++
 tb/tb_slice_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_seq_pkg.sv
// Shared types and elaboration helpers for the slice sequencer.
// State encoding, slice-count and index-width functions, side-band field position.
package slice_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Side-band masked field sits at held word bits [MASK_LSB +: MASK_W]
   localparam int unsigned MASK_LSB = 4;
   localparam int unsigned MASK_W   = 2;

   function automatic int unsigned slice_count(input int unsigned data_w,
                                               input int unsigned slice_w);
      return data_w / slice_w;
   endfunction

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < value) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/slice_sequencer_mux.sv
// Combinational slice selector: picks the SLICE_W-bit slice of the held word at physical index idx.
module slice_sequencer_mux
   import slice_seq_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned SLICE_W = 4
) (
   input  logic [DATA_W-1:0]                                      held,
   input  logic [clog2(slice_count(DATA_W, SLICE_W))-1:0]         idx,
   output logic [SLICE_W-1:0]                                     slice
);

   localparam int unsigned N     = slice_count(DATA_W, SLICE_W);
   localparam int unsigned IDX_W = clog2(N);

   always_comb begin
      slice = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (idx == IDX_W'(i)) begin
            slice = held[i*SLICE_W +: SLICE_W];
         end
      end
   end

endmodule

// File: rtl/slice_sequencer.sv
// Serializes accepted words into slices over a valid/ready pair, with per-word side-band taps
// and a completed-word counter. Back-to-back words are chained without a bubble.
module slice_sequencer
   import slice_seq_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned SLICE_W   = 4,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              in_valid,
   output logic                                              in_ready,
   input  logic [DATA_W-1:0]                                 in_data,
   input  logic [3:0]                                        in_addr,
   output logic                                              out_valid,
   input  logic                                              out_ready,
   output logic [SLICE_W-1:0]                                out_slice,
   output logic [clog2(slice_count(DATA_W, SLICE_W))-1:0]    out_idx,
   output logic                                              out_last,
   output logic                                              out_bit0,
   output logic [1:0]                                        out_mask,
   output logic [7:0]                                        word_cnt
);

   localparam int unsigned N     = slice_count(DATA_W, SLICE_W);
   localparam int unsigned IDX_W = clog2(N);

   state_t              state, state_d;
   logic [IDX_W-1:0]    cnt, cnt_d;
   logic [DATA_W-1:0]   held, held_d;
   logic                valid_d;
   logic                bit0_d;
   logic [1:0]          mask_d;
   logic [7:0]          word_cnt_d;
   logic [IDX_W-1:0]    idx_d;
   logic                last_d;
   logic [SLICE_W-1:0]  slice_d;
   logic [MASK_W-1:0]   field;
   logic                slice_hs;
   logic                accept;
   logic                load;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^in_addr[3:2];

   // A word may enter when idle or exactly as the final slice of the current word leaves
   assign slice_hs = out_valid & out_ready;
   assign in_ready = ~rst & ((state == IDLE) | (slice_hs & out_last));
   assign accept   = in_valid & in_ready;

   // Extract the side-band field from the incoming word; absent bits read as zero
   always_comb begin
      field = '0;
      for (int i = 0; i < int'(MASK_W); i++) begin
         if (MASK_LSB + i < DATA_W) begin
            field[i] = in_data[MASK_LSB + i];
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      held_d     = held;
      valid_d    = out_valid;
      bit0_d     = out_bit0;
      mask_d     = out_mask;
      word_cnt_d = word_cnt;
      load       = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               state_d = EMIT;
               load    = 1'b1;
            end
         end
         EMIT: begin
            if (slice_hs) begin
               if (!out_last) begin
                  cnt_d = cnt + IDX_W'(1);
               end else begin
                  word_cnt_d = word_cnt + 8'd1;
                  if (accept) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

      if (load) begin
         cnt_d   = '0;
         held_d  = in_data;
         valid_d = 1'b1;
         bit0_d  = in_data[0];
         mask_d  = field & in_addr[1:0];
      end
   end

   // Physical index and last flag follow the emit counter of the next cycle
   assign idx_d  = MSB_FIRST ? (IDX_W'(N - 1) - cnt_d) : cnt_d;
   assign last_d = (cnt_d == IDX_W'(N - 1));

   slice_sequencer_mux #(
      .DATA_W  (DATA_W),
      .SLICE_W (SLICE_W)
   ) u_mux (
      .held  (held_d),
      .idx   (idx_d),
      .slice (slice_d)
   );

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         held      <= '0;
         out_valid <= 1'b0;
         out_slice <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_bit0  <= 1'b0;
         out_mask  <= '0;
         word_cnt  <= '0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         held      <= held_d;
         out_valid <= valid_d;
         out_slice <= slice_d;
         out_idx   <= idx_d;
         out_last  <= last_d;
         out_bit0  <= bit0_d;
         out_mask  <= mask_d;
         word_cnt  <= word_cnt_d;
      end
   end

endmodule

// File: tb/tb_slice_sequencer.sv
// Self-checking bench for slice_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model (LSB-first and MSB-first instances).
module tb_slice_sequencer;

   localparam int unsigned DW = 8;
   localparam int unsigned SW = 4;
   localparam int unsigned N  = DW / SW;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic [3:0] in_addr;
   logic       out_ready;

   logic       ir0, ov0, id0, la0, b00;
   logic [3:0] sl0;
   logic [1:0] mk0;
   logic [7:0] wc0;
   logic       ir1, ov1, id1, la1, b01;
   logic [3:0] sl1;
   logic [1:0] mk1;
   logic [7:0] wc1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   slice_sequencer #(.DATA_W(DW), .SLICE_W(SW), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
      .in_addr(in_addr), .out_valid(ov0), .out_ready(out_ready), .out_slice(sl0),
      .out_idx(id0), .out_last(la0), .out_bit0(b00), .out_mask(mk0), .word_cnt(wc0));

   slice_sequencer #(.DATA_W(DW), .SLICE_W(SW), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .in_addr(in_addr), .out_valid(ov1), .out_ready(out_ready), .out_slice(sl1),
      .out_idx(id1), .out_last(la1), .out_bit0(b01), .out_mask(mk1), .word_cnt(wc1));

   // Reference model: queue of slices still to be emitted for the current word
   typedef struct {
      logic [3:0] slice;
      logic       idx;
      logic       last;
   } ent_t;

   ent_t       q0[$];
   ent_t       q1[$];
   logic [7:0] m_cnt  = 8'd0;
   logic       m_b0   = 1'b0;
   logic [1:0] m_mask = 2'b00;

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic [3:0] a;
      logic       rdy;
      logic       ev;
      logic [3:0] s0;
      logic       i0;
      logic [3:0] s1;
      logic       i1;
      logic       el;
      logic       eir;
      logic [7:0] wc;
      logic       b0;
      logic [1:0] m;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic [3:0] a,
                               input logic rdy, input logic ev, input logic [3:0] s0,
                               input logic i0, input logic [3:0] s1, input logic i1,
                               input logic el, input logic eir, input logic [7:0] wc,
                               input logic b0, input logic [1:0] m);
      vec_t v;
      v.iv = iv; v.d = d; v.a = a; v.rdy = rdy; v.ev = ev; v.s0 = s0; v.i0 = i0;
      v.s1 = s1; v.i1 = i1; v.el = el; v.eir = eir; v.wc = wc; v.b0 = b0; v.m = m;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [7:0] d, input logic [3:0] a,
                        input logic rdy, input logic r);
      rst = r; in_valid = iv; in_data = d; in_addr = a; out_ready = rdy;
      #1;
   endtask

   // Compare both DUTs against the model, advance the model, then move to the next cycle
   task automatic model_step();
      logic exp_ir;
      logic lst;
      ent_t e;
      exp_ir = !rst && (q0.size() == 0 || (q0.size() == 1 && out_ready));
      chk("in_ready",      32'(ir0), 32'(exp_ir));
      chk("in_ready_msb",  32'(ir1), 32'(exp_ir));
      chk("out_valid",     32'(ov0), 32'(q0.size() != 0));
      chk("out_valid_msb", 32'(ov1), 32'(q1.size() != 0));
      chk("word_cnt",      32'(wc0), 32'(m_cnt));
      chk("word_cnt_msb",  32'(wc1), 32'(m_cnt));
      chk("out_bit0",      32'(b00), 32'(m_b0));
      chk("out_mask",      32'(mk0), 32'(m_mask));
      chk("out_mask_msb",  32'(mk1), 32'(m_mask));
      if (q0.size() != 0) begin
         chk("out_slice",     32'(sl0), 32'(q0[0].slice));
         chk("out_idx",       32'(id0), 32'(q0[0].idx));
         chk("out_last",      32'(la0), 32'(q0[0].last));
         chk("out_slice_msb", 32'(sl1), 32'(q1[0].slice));
         chk("out_idx_msb",   32'(id1), 32'(q1[0].idx));
         chk("out_last_msb",  32'(la1), 32'(q1[0].last));
      end
      if (rst) begin
         q0.delete(); q1.delete();
         m_cnt = 8'd0; m_b0 = 1'b0; m_mask = 2'b00;
      end else begin
         if (q0.size() != 0 && out_ready) begin
            lst = q0[0].last;
            void'(q0.pop_front());
            void'(q1.pop_front());
            if (lst) m_cnt = m_cnt + 8'd1;
         end
         if (in_valid && exp_ir) begin
            for (int k = 0; k < int'(N); k++) begin
               e.idx   = 1'(k);
               e.slice = 4'(in_data >> (SW * k));
               e.last  = (k == int'(N) - 1);
               q0.push_back(e);
               e.idx   = 1'(int'(N) - 1 - k);
               e.slice = 4'(in_data >> (SW * (int'(N) - 1 - k)));
               q1.push_back(e);
            end
            m_b0   = in_data[0];
            m_mask = in_data[5:4] & in_addr[1:0];
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_addr = 4'h0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values
      drive(1'b1, 8'hFF, 4'hF, 1'b1, 1'b1);
      chk("rst_out_valid", 32'(ov0), 32'd0);
      chk("rst_in_ready",  32'(ir0), 32'd0);
      chk("rst_out_slice", 32'(sl0), 32'd0);
      chk("rst_out_idx",   32'(id0), 32'd0);
      chk("rst_out_idx_msb", 32'(id1), 32'd0);
      chk("rst_out_last",  32'(la0), 32'd0);
      chk("rst_out_bit0",  32'(b00), 32'd0);
      chk("rst_out_mask",  32'(mk0), 32'd0);
      chk("rst_word_cnt",  32'(wc0), 32'd0);
      model_step();

      // Directed table: A5 word, backpressured 3C, back-to-back 3C then 81
      tv.push_back(mk(1'b1, 8'hA5, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 2'b00));
      tv.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 4'h5, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 2'b10));
      tv.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 4'hA, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 2'b10));
      tv.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 2'b10));
      tv.push_back(mk(1'b1, 8'h3C, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 2'b10));
      for (int i = 0; i < 3; i++)
         tv.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 4'hC, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 2'b00));
      tv.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 4'hC, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 2'b00));
      tv.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 2'b00));
      tv.push_back(mk(1'b1, 8'h3C, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 2'b00));
      tv.push_back(mk(1'b1, 8'h81, 4'h1, 1'b1, 1'b1, 4'hC, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 2'b01));
      tv.push_back(mk(1'b1, 8'h81, 4'h1, 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 2'b01));
      tv.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 2'b00));
      tv.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 4'h8, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 2'b00));
      tv.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1, 2'b00));

      for (int i = 0; i < tv.size(); i++) begin
         v = tv[i];
         drive(v.iv, v.d, v.a, v.rdy, 1'b0);
         chk("tv_out_valid", 32'(ov0), 32'(v.ev));
         chk("tv_in_ready",  32'(ir0), 32'(v.eir));
         chk("tv_word_cnt",  32'(wc0), 32'(v.wc));
         chk("tv_out_bit0",  32'(b00), 32'(v.b0));
         chk("tv_out_mask",  32'(mk0), 32'(v.m));
         if (v.ev) begin
            chk("tv_out_slice",     32'(sl0), 32'(v.s0));
            chk("tv_out_idx",       32'(id0), 32'(v.i0));
            chk("tv_out_last",      32'(la0), 32'(v.el));
            chk("tv_out_slice_msb", 32'(sl1), 32'(v.s1));
            chk("tv_out_idx_msb",   32'(id1), 32'(v.i1));
            chk("tv_out_last_msb",  32'(la1), 32'(v.el));
         end
         model_step();
      end

      // Reset mid-word: low slice taken, reset hits before the high slice is taken
      drive(1'b1, 8'hF0, 4'h0, 1'b1, 1'b0);
      model_step();
      drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      chk("mid_first_slice", 32'(sl0), 32'h0);
      model_step();
      drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b1);
      chk("mid_rst_in_ready", 32'(ir0), 32'd0);
      model_step();
      drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      chk("mid_out_valid", 32'(ov0), 32'd0);
      chk("mid_word_cnt",  32'(wc0), 32'd0);
      chk("mid_in_ready",  32'(ir0), 32'd1);
      model_step();
      drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      chk("mid_no_high_slice", 32'(ov0), 32'd0);
      model_step();

      // Counter wrap: 256 back-to-back words, then one more
      for (int c = 0; c < 512; c++) begin
         drive(1'b1, 8'(c * 7 + 3), 4'(c), 1'b1, 1'b0);
         model_step();
      end
      drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      model_step();
      drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      chk("wrap_256", 32'(wc0), 32'd0);
      chk("wrap_idle", 32'(ov0), 32'd0);
      model_step();
      drive(1'b1, 8'h5A, 4'h2, 1'b1, 1'b0);
      model_step();
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
         model_step();
      end
      drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      chk("wrap_257", 32'(wc0), 32'd1);
      model_step();

      // Randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
         model_step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
